// File: rtl/fp_mask.sv
// fp_mask: front-end field extraction for the binary32 FP adder.
// Splits operands A and B into sign/exponent/mantissa fields, builds the
// hidden-bit significand, classifies each operand, and compares the
// magnitudes. Everything is captured in one register stage; the data
// registers load only on in_valid, and out_valid follows in_valid.
module fp_mask (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic        sign_a,
  output logic        sign_b,
  output logic [7:0]  exponent_a,
  output logic [7:0]  exponent_b,
  output logic [22:0] mantissa_a,
  output logic [22:0] mantissa_b,
  output logic [23:0] signif_a,
  output logic [23:0] signif_b,
  output logic        zero_a,
  output logic        denorm_a,
  output logic        inf_a,
  output logic        nan_a,
  output logic        zero_b,
  output logic        denorm_b,
  output logic        inf_b,
  output logic        nan_b,
  output logic        a_mag_ge_b
);

  // Per-operand decoded view; one register of this type per operand.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
    logic [23:0] signif;
    logic        zero;
    logic        denorm;
    logic        inf;
    logic        nan;
  } fields_t;

  // Pure bit slicing plus class decode; no bias removal or normalisation.
  function automatic fields_t split(input logic [31:0] x);
    fields_t f;
    logic    e_zero;
    logic    e_ones;
    logic    m_zero;
    e_zero     = (x[30:23] == 8'h00);
    e_ones     = (x[30:23] == 8'hFF);
    m_zero     = (x[22:0] == 23'd0);
    f.sign     = x[31];
    f.exponent = x[30:23];
    f.mantissa = x[22:0];
    // Hidden bit is set for normals, inf and NaN alike.
    f.signif   = {~e_zero, x[22:0]};
    f.zero     = e_zero & m_zero;
    f.denorm   = e_zero & ~m_zero;
    f.inf      = e_ones & m_zero;
    f.nan      = e_ones & ~m_zero;
    return f;
  endfunction

  fields_t next_a;
  fields_t next_b;
  logic    next_ge;
  fields_t reg_a;
  fields_t reg_b;
  logic    reg_ge;
  logic    reg_valid;

  // Decode the incoming pair ahead of the capture register.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    next_a  = split(a);
    next_b  = split(b);
    // Sign bit excluded; +0/-0 and equal magnitudes compare as >=.
    next_ge = (a[30:0] >= b[30:0]);
  end

  // Capture register: valid tracks in_valid every edge, data loads on in_valid.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_valid <= 1'b0;
      reg_a     <= '0;
      reg_b     <= '0;
      reg_ge    <= 1'b0;
    end else begin
      reg_valid <= in_valid;
      if (in_valid) begin
        reg_a  <= next_a;
        reg_b  <= next_b;
        reg_ge <= next_ge;
      end
    end
  end

  assign out_valid  = reg_valid;
  assign sign_a     = reg_a.sign;
  assign exponent_a = reg_a.exponent;
  assign mantissa_a = reg_a.mantissa;
  assign signif_a   = reg_a.signif;
  assign zero_a     = reg_a.zero;
  assign denorm_a   = reg_a.denorm;
  assign inf_a      = reg_a.inf;
  assign nan_a      = reg_a.nan;
  assign sign_b     = reg_b.sign;
  assign exponent_b = reg_b.exponent;
  assign mantissa_b = reg_b.mantissa;
  assign signif_b   = reg_b.signif;
  assign zero_b     = reg_b.zero;
  assign denorm_b   = reg_b.denorm;
  assign inf_b      = reg_b.inf;
  assign nan_b      = reg_b.nan;
  assign a_mag_ge_b = reg_ge;

endmodule

// File: tb/tb_fp_mask.sv
// Self-checking bench for fp_mask: directed table, hold, mid-stream reset,
// and a biased random sweep against an independent arithmetic model.
module tb_fp_mask;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        sign_a, sign_b;
  logic [7:0]  exponent_a, exponent_b;
  logic [22:0] mantissa_a, mantissa_b;
  logic [23:0] signif_a, signif_b;
  logic        zero_a, denorm_a, inf_a, nan_a;
  logic        zero_b, denorm_b, inf_b, nan_b;
  logic        a_mag_ge_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_mask dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .sign_a     (sign_a),
    .sign_b     (sign_b),
    .exponent_a (exponent_a),
    .exponent_b (exponent_b),
    .mantissa_a (mantissa_a),
    .mantissa_b (mantissa_b),
    .signif_a   (signif_a),
    .signif_b   (signif_b),
    .zero_a     (zero_a),
    .denorm_a   (denorm_a),
    .inf_a      (inf_a),
    .nan_a      (nan_a),
    .zero_b     (zero_b),
    .denorm_b   (denorm_b),
    .inf_b      (inf_b),
    .nan_b      (nan_b),
    .a_mag_ge_b (a_mag_ge_b)
  );

  // Operand record: {sign, exponent, mantissa, signif, zero, denorm, inf, nan}.
  typedef logic [59:0]  opf_t;
  // Full observation: {out_valid, A record, B record, a_mag_ge_b}.
  typedef logic [121:0] obs_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    opf_t        fa;
    opf_t        fb;
    logic        ge;
  } vec_t;

  function automatic opf_t mk(input logic s, input logic [7:0] e, input logic [22:0] m,
                              input logic [23:0] sg, input logic [3:0] cls);
    return {s, e, m, sg, cls};
  endfunction

  // Reference model written arithmetically, independent of the RTL slicing.
  function automatic opf_t model(input logic [31:0] x);
    logic [31:0] e32;
    logic [31:0] m32;
    logic [31:0] sg32;
    logic [3:0]  cls;
    e32  = (x >> 23) & 32'hFF;
    m32  = x & 32'h7FFFFF;
    sg32 = m32 + ((e32 != 0) ? 32'h800000 : 32'h0);
    cls  = {(e32 == 0) && (m32 == 0), (e32 == 0) && (m32 != 0),
            (e32 == 255) && (m32 == 0), (e32 == 255) && (m32 != 0)};
    return {x[31], e32[7:0], m32[22:0], sg32[23:0], cls};
  endfunction

  function automatic logic model_ge(input logic [31:0] x, input logic [31:0] y);
    return (x & 32'h7FFFFFFF) >= (y & 32'h7FFFFFFF);
  endfunction

  function automatic obs_t observe();
    return {out_valid,
            sign_a, exponent_a, mantissa_a, signif_a, zero_a, denorm_a, inf_a, nan_a,
            sign_b, exponent_b, mantissa_b, signif_b, zero_b, denorm_b, inf_b, nan_b,
            a_mag_ge_b};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drive away from the edge, clock once, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [31:0] xa, input logic [31:0] xb);
    @(negedge clk);
    in_valid = v;
    a        = xa;
    b        = xb;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];
  obs_t held;
  obs_t want;
  opf_t cur_a, cur_b;
  logic cur_ge;

  initial begin
    // Hand-computed directed vectors.
    vecs[0] = '{32'h3F800000, 32'hC0490FDB,
                mk(0, 8'h7F, 23'h000000, 24'h800000, 4'b0000),
                mk(1, 8'h80, 23'h490FDB, 24'hC90FDB, 4'b0000), 1'b0};
    vecs[1] = '{32'h7FC00000, 32'hFF800000,
                mk(0, 8'hFF, 23'h400000, 24'hC00000, 4'b0001),
                mk(1, 8'hFF, 23'h000000, 24'h800000, 4'b0010), 1'b1};
    vecs[2] = '{32'h80000000, 32'h00000001,
                mk(1, 8'h00, 23'h000000, 24'h000000, 4'b1000),
                mk(0, 8'h00, 23'h000001, 24'h000001, 4'b0100), 1'b0};
    vecs[3] = '{32'h00000000, 32'h80000000,
                mk(0, 8'h00, 23'h000000, 24'h000000, 4'b1000),
                mk(1, 8'h00, 23'h000000, 24'h000000, 4'b1000), 1'b1};
    vecs[4] = '{32'h7F800001, 32'h7FFFFFFF,
                mk(0, 8'hFF, 23'h000001, 24'h800001, 4'b0001),
                mk(0, 8'hFF, 23'h7FFFFF, 24'hFFFFFF, 4'b0001), 1'b0};
    vecs[5] = '{32'h00800000, 32'h007FFFFF,
                mk(0, 8'h01, 23'h000000, 24'h800000, 4'b0000),
                mk(0, 8'h00, 23'h7FFFFF, 24'h7FFFFF, 4'b0100), 1'b1};
    vecs[6] = '{32'h3F800000, 32'hBF800000,
                mk(0, 8'h7F, 23'h000000, 24'h800000, 4'b0000),
                mk(1, 8'h7F, 23'h000000, 24'h800000, 4'b0000), 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 32'hFFFFFFFF;
    b        = 32'hFFFFFFFF;
    #12;
    check("reset_state", observe(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; the last entry leads into the hold check.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b);
      want = {1'b1, vecs[i].fa, vecs[i].fb, vecs[i].ge};
      check($sformatf("vec%0d", i), observe(), want);
    end

    // Idle cycles with junk on a/b: fields hold, out_valid drops.
    held = want;
    held[121] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $urandom, $urandom);
      check($sformatf("hold%0d", i), observe(), held);
    end

    // Mid-stream reset: capture one pair, then pull rst_n low between edges.
    step(1'b1, vecs[1].a, vecs[1].b);
    check("pre_reset", observe(), {1'b1, vecs[1].fa, vecs[1].fb, vecs[1].ge});
    @(negedge clk);
    in_valid = 1'b1;
    a        = vecs[2].a;
    b        = vecs[2].b;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", observe(), '0);
    @(posedge clk);
    #1;
    check("reset_held", observe(), '0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    a        = vecs[0].a;
    b        = vecs[0].b;
    #1;
    check("release_no_edge", observe(), '0);
    @(posedge clk);
    #1;
    check("first_after_reset", observe(), {1'b1, vecs[0].fa, vecs[0].fb, vecs[0].ge});

    // Random sweep, biased toward zero/denorm/inf/NaN exponents.
    cur_a  = vecs[0].fa;
    cur_b  = vecs[0].fb;
    cur_ge = vecs[0].ge;
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] ra, rb;
      logic        rv;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra[30:23] = 8'h00;
        1: ra[30:23] = 8'hFF;
        2: rb[30:23] = 8'h00;
        3: rb[30:23] = 8'hFF;
        4: rb = ra ^ 32'h80000000;
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) ra[22:0] = '0;
      if ($urandom_range(0, 15) == 0) rb[22:0] = '0;
      rv = ($urandom_range(0, 3) != 0);
      step(rv, ra, rb);
      if (rv) begin
        cur_a  = model(ra);
        cur_b  = model(rb);
        cur_ge = model_ge(ra, rb);
      end
      check($sformatf("rand%0d", i), observe(), {rv, cur_a, cur_b, cur_ge});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
